// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin share of one 8/8 divider among NREQ requesters.
// Sequences issue -> capture -> divider re-arm (div_clr_n pulse) -> recovery gap.
// Optional build macro DIV_ZERO_BYPASS_EN: zero divisors complete locally without
// using the divider and raise dz_err; otherwise they go to the divider unchanged.
module divider_arbiter #(
  parameter  int unsigned NREQ        = 4,
  parameter  int unsigned TIMEOUT_CYC = 63,
  localparam int unsigned IDW         = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [16*NREQ-1:0] values,
  output logic [NREQ-1:0]   ack,
  output logic [15:0]       result,
  output logic [IDW-1:0]    result_id,
  output logic              busy,
  output logic              timeout_err,
  output logic              dz_err,
  output logic              div_req,
  output logic [15:0]       div_values,
  input  logic              div_ack,
  input  logic [15:0]       div_result,
  output logic              div_clr_n
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE, GAP} state_t;

  state_t          state;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  gnt_id;
  logic [TW-1:0]   timer;

  logic [15:0]     slice [NREQ];
  logic            gnt_vld_c;
  logic [IDW-1:0]  gnt_id_c;
  logic [IDW-1:0]  cand_c;
  logic [15:0]     gnt_val_c;

  // Unpack the flat operand bus into one 16-bit slice per requester
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      slice[i] = values[16*i +: 16];
    end
  end

  // Round-robin pick: first requester set after the pointer, wrapping mod NREQ
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_id_c  = '0;
    cand_c    = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand_c = IDW'((32'(rr_ptr) + i) % NREQ);
      if (!gnt_vld_c && req[cand_c]) begin
        gnt_vld_c = 1'b1;
        gnt_id_c  = cand_c;
      end
    end
    gnt_val_c = slice[gnt_id_c];
  end

  // Sequencer FSM; every output is a register updated on state transitions
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= IDW'(NREQ - 1);
      gnt_id      <= '0;
      timer       <= '0;
      ack         <= '0;
      result      <= '0;
      result_id   <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      dz_err      <= 1'b0;
`endif
      div_req     <= 1'b0;
      div_values  <= '0;
      div_clr_n   <= 1'b1;
    end else begin
      ack         <= '0;
      timeout_err <= 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
      dz_err      <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (gnt_vld_c) begin
            rr_ptr     <= gnt_id_c;
            gnt_id     <= gnt_id_c;
            div_values <= gnt_val_c;
            timer      <= '0;
            busy       <= 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
            if (gnt_val_c[7:0] == 8'h00) begin
              // zero divisor: complete locally, the divider is never started
              result    <= {gnt_val_c[15:8], 8'hFF};
              result_id <= gnt_id_c;
              ack       <= NREQ'(1) << gnt_id_c;
              dz_err    <= 1'b1;
              div_clr_n <= 1'b0;
              state     <= DONE;
            end else begin
              div_req <= 1'b1;
              state   <= ISSUE;
            end
`else
            div_req <= 1'b1;
            state   <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          // div_ack has priority over a simultaneous timeout
          if (div_ack || (timer == TW'(TIMEOUT_CYC - 1))) begin
            result      <= div_ack ? div_result : 16'hFFFF;
            timeout_err <= ~div_ack;
            result_id   <= gnt_id;
            ack         <= NREQ'(1) << gnt_id;
            div_req     <= 1'b0;
            div_clr_n   <= 1'b0;
            state       <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          div_clr_n <= 1'b1;
          state     <= GAP;
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef DIV_ZERO_BYPASS_EN
  assign dz_err = 1'b0;
`endif

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter: vector table plus multi-cycle corner sequences.
module tb_divider_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TOUT = 63;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [63:0] values;
  logic [3:0]  ack;
  logic [15:0] result;
  logic [1:0]  result_id;
  logic        busy, timeout_err, dz_err, div_req, div_ack, div_clr_n;
  logic [15:0] div_values, div_result;

  int n_total = 0;
  int n_pass  = 0;

  // divider model controls
  bit stall   = 1'b0;
  int ack_dly = 2;
  int dcnt;

  divider_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .values(values), .ack(ack),
    .result(result), .result_id(result_id), .busy(busy), .timeout_err(timeout_err),
    .dz_err(dz_err), .div_req(div_req), .div_values(div_values), .div_ack(div_ack),
    .div_result(div_result), .div_clr_n(div_clr_n)
  );

  always #5 clk = ~clk;

  // divider model: one div_ack pulse after ack_dly+1 cycles of div_req unless stalled
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_ack    <= 1'b0;
      div_result <= 16'h0;
      dcnt       <= 0;
    end else begin
      div_ack <= 1'b0;
      if (div_req && !div_ack && !stall) begin
        if (dcnt == ack_dly) begin
          div_ack <= 1'b1;
          if (div_values[7:0] == 8'h00)
            div_result <= {div_values[15:8], 8'hFF};
          else
            div_result <= {div_values[15:8] % div_values[7:0], div_values[15:8] / div_values[7:0]};
          dcnt <= 0;
        end else begin
          dcnt <= dcnt + 1;
        end
      end else begin
        dcnt <= 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // wait (bounded) for an ack pulse, counting cycles and div_req-high cycles
  task automatic run_op(input string nm, output int cyc, output int dreq);
    bit got;
    got = 1'b0; cyc = 0; dreq = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (div_req) dreq++;
      if (|ack) got = 1'b1;
    end
    chk({nm, "_ack_seen"}, 64'(got), 64'd1);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [63:0] vals;
    logic [1:0]  id;
    logic [15:0] res;
  } vec_t;

  vec_t        tbl [6];
  logic [1:0]  rr_id  [5];
  logic [15:0] rr_res [5];
  int          cyc, dreq;
  bit          seen3;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {req, {slot3,slot2,slot1,slot0}, expected id, {rem,quot}}; pointer carries over
    tbl[0] = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h6407}, 2'd0, 16'h020E}; // 100/7
    tbl[1] = '{4'b0100, {16'h0000, 16'hC80A, 16'h0000, 16'h0000}, 2'd2, 16'h0014}; // 200/10
    tbl[2] = '{4'b1001, {16'h3105, 16'h0000, 16'h0000, 16'hFF10}, 2'd3, 16'h0409}; // ptr2 -> 3
    tbl[3] = '{4'b1001, {16'h3105, 16'h0000, 16'h0000, 16'hFF10}, 2'd0, 16'h0F0F}; // wrap -> 0
    tbl[4] = '{4'b0110, {16'h0000, 16'hFF01, 16'h0703, 16'h0000}, 2'd1, 16'h0102}; // ptr0 -> 1
    tbl[5] = '{4'b1010, {16'h8080, 16'h0000, 16'h0A0B, 16'h0000}, 2'd3, 16'h0001}; // ptr1 -> 3

    rr_id[0] = 2'd0; rr_id[1] = 2'd1; rr_id[2] = 2'd2; rr_id[3] = 2'd3; rr_id[4] = 2'd0;
    rr_res[0] = 16'h020E; rr_res[1] = 16'h0102; rr_res[2] = 16'h0014;
    rr_res[3] = 16'h0409; rr_res[4] = 16'h020E;

    reset_n = 1'b0; req = '0; values = '0;
    #12;
    chk("reset_outs", 64'({ack, result, result_id, busy, timeout_err, dz_err, div_req, div_values, div_clr_n}), 64'd1);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // table vectors: one requester set (or a pair) per operation
    for (int k = 0; k < 6; k++) begin
      req = tbl[k].req; values = tbl[k].vals;
      run_op($sformatf("v%0d", k), cyc, dreq);
      chk($sformatf("v%0d_ackvec", k), 64'(ack), 64'(4'b0001 << tbl[k].id));
      chk($sformatf("v%0d_res", k), 64'(result), 64'(tbl[k].res));
      chk($sformatf("v%0d_id", k), 64'(result_id), 64'(tbl[k].id));
      chk($sformatf("v%0d_errs", k), 64'({timeout_err, dz_err}), 64'd0);
      chk($sformatf("v%0d_clr", k), 64'(div_clr_n), 64'd0);
      req = '0;
      @(negedge clk); @(negedge clk);
      chk($sformatf("v%0d_idle", k), 64'({busy, div_clr_n}), 64'b01);
    end

    // all four held: pointer at 3, so order is 0,1,2,3,0
    values = {16'h3105, 16'hC80A, 16'h0703, 16'h6407};
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      run_op($sformatf("rr%0d", k), cyc, dreq);
      chk($sformatf("rr%0d_ackvec", k), 64'(ack), 64'(4'b0001 << rr_id[k]));
      chk($sformatf("rr%0d_res", k), 64'(result), 64'(rr_res[k]));
      if (k == 4) req = '0;
    end
    @(negedge clk); @(negedge clk);

    // stalled divider: div_req held exactly TOUT cycles, then aborted result
    stall = 1'b1;
    values = {16'h0000, 16'h0000, 16'h0503, 16'h0000};
    req = 4'b0010;
    run_op("tmo", cyc, dreq);
    req = '0;
    chk("tmo_dreq_cycles", 64'(dreq), 64'(TOUT));
    chk("tmo_latency", 64'(cyc), 64'(TOUT + 1));
    chk("tmo_res", 64'({ack, result, result_id, timeout_err}), 64'({4'b0010, 16'hFFFF, 2'd1, 1'b1}));
    stall = 1'b0;
    @(negedge clk); @(negedge clk);
    values = {16'h0000, 16'h0A03, 16'h0000, 16'h0000};
    req = 4'b0100;
    run_op("post_tmo", cyc, dreq);
    req = '0;
    chk("post_tmo_res", 64'({ack, result, result_id, timeout_err}), 64'({4'b0100, 16'h0103, 2'd2, 1'b0}));
    @(negedge clk); @(negedge clk);

    // div_ack arrives in the last ISSUE cycle: div_ack wins, no error
    ack_dly = TOUT - 2;
    values = {16'h3105, 16'h0000, 16'h0000, 16'h0000};
    req = 4'b1000;
    run_op("edge", cyc, dreq);
    req = '0;
    chk("edge_dreq_cycles", 64'(dreq), 64'(TOUT));
    chk("edge_res", 64'({ack, result, timeout_err}), 64'({4'b1000, 16'h0409, 1'b0}));
    ack_dly = 2;
    @(negedge clk); @(negedge clk);

    // zero divisor on requester 1 (pointer at 3 -> 1 wins)
    values = {16'h0000, 16'h0000, 16'h2A00, 16'h0000};
    req = 4'b0010;
    run_op("dz", cyc, dreq);
    req = '0;
    chk("dz_ackvec", 64'(ack), 64'(4'b0010));
`ifdef DIV_ZERO_BYPASS_EN
    chk("dz_res", 64'({result, dz_err}), 64'({16'h2AFF, 1'b1}));
    chk("dz_no_divreq", 64'(dreq), 64'd0);
`else
    chk("dz_flag", 64'(dz_err), 64'd0);
    chk("dz_divreq_used", 64'(dreq > 0), 64'd1);
`endif
    @(negedge clk); @(negedge clk);

    // reset during ISSUE after granting requester 2 (pointer would be 2)
    stall = 1'b1;
    values = {16'h8080, 16'h0A03, 16'h0000, 16'h0000};
    req = 4'b0100;
    repeat (5) @(negedge clk);
    chk("mid_busy", 64'({busy, div_req}), 64'b11);
    reset_n = 1'b0; req = '0;
    #1;
    chk("mid_reset_outs", 64'({ack, result, result_id, busy, timeout_err, dz_err, div_req, div_values, div_clr_n}), 64'd1);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1; stall = 1'b0;
    @(negedge clk);
    // 2 and 3 both pending: reset pointer (3) selects 2; a stale pointer would select 3
    req = 4'b1100;
    @(negedge clk); req = 4'b0100;
    @(negedge clk); req = 4'b1100;
    @(negedge clk); req = 4'b0100;
    run_op("post_rst", cyc, dreq);
    req = '0;
    chk("post_rst_res", 64'({ack, result, result_id}), 64'({4'b0100, 16'h0103, 2'd2}));
    seen3 = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ack[3]) seen3 = 1'b1;
    end
    chk("no_ack3", 64'(seen3), 64'd0);
    chk("final_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
